lsu_subword: RTL and testbench

// - Load/store unit between the RISC-V core datapath and the word-only data port of the shared memory.

---
 rtl/lsu_subword.sv | 206 ++++++++++++++++++++
 tb/tb_lsu_subword.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_subword.sv
// lsu_subword: byte/half/word load-store unit in front of a word-only memory port.
// Loads pick and extend one lane of the addressed word. Sub-word stores read the
// word, merge the new lane in and write the whole word back.
// Build option: define MISALIGN_TRAP_EN to answer misaligned requests with
// resp_error instead of silently aligning them.
//
// Handshake: a request is taken on a rising clk edge where req_valid and req_ready
// are both high. req_ready is high only in IDLE, so one transaction is in flight at
// a time and the req_* inputs are ignored while busy. resp_valid is a single-cycle
// pulse with no back-pressure; resp_rdata/resp_error stay valid until the next response.
module lsu_subword #(
  parameter int RESP_REG = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_ra,
  input  logic [31:0] mem_rd,
  output logic        mem_we,
  output logic [31:0] mem_wa,
  output logic [31:0] mem_wd
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MERGE = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;
  logic [31:0] wd_q;
  logic [31:0] rdata_q;
  logic [31:0] acc_addr;
  logic [31:0] word_addr;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

`ifdef MISALIGN_TRAP_EN
  logic misalign;
  logic err_q;

  // Half with addr[0] set, or word (size 10/11) with any low bit set, is misaligned.
  always_comb begin
    misalign = ((req_size == 2'b01) && req_addr[0]) ||
               (req_size[1] && (req_addr[1:0] != 2'b00));
  end
`endif

  // Clear the low address bits a half or word access cannot use.
  always_comb begin
    acc_addr = req_addr;
    if (req_size == 2'b01) begin
      acc_addr[0] = 1'b0;
    end else if (req_size[1]) begin
      acc_addr[1:0] = 2'b00;
    end
  end

  assign word_addr = {addr_q[31:2], 2'b00};

  // Select the addressed lane of the read word and sign/zero extend it.
  always_comb begin
    lane_b = mem_rd[{addr_q[1:0], 3'b000} +: 8];
    lane_h = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'b01:   load_ext = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: load_ext = mem_rd;
    endcase
  end

  // Replace the addressed byte or half of the read word with the store data.
  always_comb begin
    merged = mem_rd;
    if (size_q == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: loads read once, word stores write directly, sub-word stores merge first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (!req_we) begin
            state_d = S_LOAD;
          end else if (req_size[1]) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_MERGE;
          end
`ifdef MISALIGN_TRAP_EN
          if (misalign) begin
            state_d = S_RESP;
          end
`endif
        end
      end
      S_LOAD:  state_d = S_RESP;
      S_MERGE: state_d = S_WRITE;
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, merged write word and response data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= acc_addr;
            wdata_q <= req_wdata[15:0];
            wd_q    <= req_wdata;
`ifdef MISALIGN_TRAP_EN
            if (misalign) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
            end
`endif
          end
        end
        S_LOAD: begin
          // Only the registered response path exists; RESP_REG=0 is reserved.
          if (RESP_REG != 0) begin
            rdata_q <= load_ext;
          end
`ifdef MISALIGN_TRAP_EN
          err_q <= 1'b0;
`endif
        end
        S_MERGE: begin
          wd_q <= merged;
        end
        S_WRITE: begin
          rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
          err_q <= 1'b0;
`endif
        end
        default: begin
        end
      endcase
    end
  end

  // Memory port and handshake outputs decoded from the current state.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    mem_ra     = ((state_q == S_LOAD) || (state_q == S_MERGE)) ? word_addr : 32'd0;
    mem_we     = (state_q == S_WRITE);
    mem_wa     = (state_q == S_WRITE) ? word_addr : 32'd0;
    mem_wd     = (state_q == S_WRITE) ? wd_q : 32'd0;
  end

  assign resp_rdata = rdata_q;
`ifdef MISALIGN_TRAP_EN
  assign resp_error = err_q;
`else
  assign resp_error = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_subword.sv
// tb_lsu_subword: directed table, corner sequences and random traffic for lsu_subword.
// Honours MISALIGN_TRAP_EN the same way as the design.
module tb_lsu_subword;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_ra;
  logic [31:0] mem_rd;
  logic        mem_we;
  logic [31:0] mem_wa;
  logic [31:0] mem_wd;

  int total = 0;
  int bad   = 0;

  lsu_subword dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .mem_ra       (mem_ra),
    .mem_rd       (mem_rd),
    .mem_we       (mem_we),
    .mem_wa       (mem_wa),
    .mem_wd       (mem_wd)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory: 1 KiB, out-of-range reads 0, writes dropped ----------------
  logic [31:0] ram [0:255];
  logic        pre_en  = 1'b0;
  logic [7:0]  pre_idx = 8'd0;
  logic [31:0] pre_val = 32'd0;

  assign mem_rd = (mem_ra < 32'd1024) ? ram[mem_ra[9:2]] : 32'd0;

  always @(posedge clk) begin
    if (pre_en) ram[pre_idx] <= pre_val;
    else if (mem_we && (mem_wa < 32'd1024)) ram[mem_wa[9:2]] <= mem_wd;
  end

  // ---------------- reference model: byte-addressed memory ----------------
  logic [7:0] ref_mem [0:1023];

  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] e_rdata, output logic e_err,
                                output int e_lat, output int e_nwe,
                                output logic [31:0] e_wa, output logic [31:0] e_wd);
    int unsigned nb;
    int unsigned lane;
    logic [31:0] a;
    logic [31:0] base;
    logic [31:0] word;
    logic [31:0] val;
    bit          inr;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    e_rdata = 32'd0; e_err = 1'b0; e_nwe = 0; e_wa = 32'd0; e_wd = 32'd0; e_lat = 2;
    if ((addr % nb) != 0) begin
`ifdef MISALIGN_TRAP_EN
      e_err = 1'b1;
      e_lat = 1;
      return;
`endif
    end
    a    = addr - (addr % nb);
    base = a - (a % 4);
    lane = a % 4;
    inr  = (base < 32'd1024);
    word = 32'd0;
    if (inr) for (int k = 0; k < 4; k++) word[8*k +: 8] = ref_mem[base + k];
    if (!we) begin
      val = 32'd0;
      for (int k = 0; k < int'(nb); k++) val[8*k +: 8] = word[8*(int'(lane) + k) +: 8];
      if (!uns && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
      e_rdata = val;
      e_lat   = 2;
    end else begin
      for (int k = 0; k < int'(nb); k++) word[8*(int'(lane) + k) +: 8] = wdata[8*k +: 8];
      e_lat = (nb == 4) ? 2 : 3;
      e_nwe = 1;
      e_wa  = base;
      e_wd  = word;
      if (inr) for (int k = 0; k < 4; k++) ref_mem[base + k] = word[8*k +: 8];
    end
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_word(input int idx, input logic [31:0] v);
    @(negedge clk);
    pre_en  = 1'b1;
    pre_idx = idx[7:0];
    pre_val = v;
    for (int k = 0; k < 4; k++) ref_mem[idx*4 + k] = v[8*k +: 8];
  endtask

  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int nwe, output logic [31:0] wa, output logic [31:0] wd);
    int  wait_n;
    bit  done;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    wait_n = 0;
    while (!req_ready && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: req_ready stayed low for %0d cycles", wait_n);
    end
    @(posedge clk);
    #1;
    // Busy phase: the design must not look at these.
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom_range(0, 3));
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 0; nwe = 0; rdata = 32'd0; err = 1'b0; wa = 32'd0; wd = 32'd0; done = 1'b0;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
      if (mem_we) begin nwe++; wa = mem_wa; wd = mem_wd; end
      if (resp_valid) begin done = 1'b1; rdata = resp_rdata; err = resp_error; end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL resp_timeout: no resp_valid within %0d cycles", lat);
    end
  endtask

  // One transaction checked against the reference model.
  task automatic model_txn(input string tag, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] e_rdata, e_wa, e_wd, rdata, wa, wd;
    logic        e_err, err;
    int          e_lat, e_nwe, lat, nwe;
    model(we, size, uns, addr, wdata, e_rdata, e_err, e_lat, e_nwe, e_wa, e_wd);
    run_txn(we, size, uns, addr, wdata, rdata, err, lat, nwe, wa, wd);
    check({tag, "_rdata"}, rdata, e_rdata);
    check({tag, "_err"}, 32'(err), 32'(e_err));
    check({tag, "_lat"}, 32'(lat), 32'(e_lat));
    check({tag, "_nwe"}, 32'(nwe), 32'(e_nwe));
    if (e_nwe != 0) begin
      check({tag, "_wa"}, wa, e_wa);
      check({tag, "_wd"}, wd, e_wd);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [31:0] exp_wd;
    int          exp_lat;
  } vec_t;

  vec_t vecs [12];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rdata, wa, wd, e_rdata, e_wa, e_wd;
    logic        err, e_err;
    int          lat, nwe, e_lat, e_nwe, mwe;
    logic [31:0] w;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;

    // Preload memory and model while the unit is held in reset.
    for (int i = 0; i < 256; i++) begin
      if (i == 0)      set_word(i, 32'h1122_3344);
      else if (i == 1) set_word(i, 32'h8899_AABB);
      else if (i == 2) set_word(i, 32'h0000_0000);
      else             set_word(i, $urandom);
    end
    @(negedge clk);
    pre_en = 1'b0;

    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_error", 32'(resp_error), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_ra", mem_ra, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h5, 32'h0,         32'hFFFF_FFAA, 32'h0,         2};
    vecs[1]  = '{1'b0, 2'd1, 1'b1, 32'h6, 32'h0,         32'h0000_8899, 32'h0,         2};
    vecs[2]  = '{1'b0, 2'd2, 1'b0, 32'h4, 32'h0,         32'h8899_AABB, 32'h0,         2};
    vecs[3]  = '{1'b1, 2'd0, 1'b0, 32'h7, 32'h0000_005A, 32'h0,         32'h5A99_AABB, 3};
    vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h4, 32'h0,         32'h5A99_AABB, 32'h0,         2};
    vecs[5]  = '{1'b1, 2'd2, 1'b0, 32'h8, 32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF, 2};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'hA, 32'h0,         32'hFFFF_DEAD, 32'h0,         2};
    vecs[7]  = '{1'b0, 2'd0, 1'b1, 32'h8, 32'h0,         32'h0000_00EF, 32'h0,         2};
    vecs[8]  = '{1'b0, 2'd3, 1'b0, 32'h8, 32'h0,         32'hDEAD_BEEF, 32'h0,         2};
    vecs[9]  = '{1'b1, 2'd1, 1'b0, 32'h4, 32'hFFFF_1234, 32'h0,         32'h5A99_1234, 3};
    vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h4, 32'h0,         32'h5A99_1234, 32'h0,         2};
    vecs[11] = '{1'b0, 2'd0, 1'b0, 32'h4, 32'h0,         32'h0000_0034, 32'h0,         2};

    for (int i = 0; i < 12; i++) begin
      model(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
            e_rdata, e_err, e_lat, e_nwe, e_wa, e_wd);
      run_txn(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
              rdata, err, lat, nwe, wa, wd);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_err", i), 32'(err), 32'd0);
      check($sformatf("vec%0d_nwe", i), 32'(nwe), 32'(vecs[i].we));
      if (vecs[i].we) begin
        check($sformatf("vec%0d_wa", i), wa, {vecs[i].addr[31:2], 2'b00});
        check($sformatf("vec%0d_wd", i), wd, vecs[i].exp_wd);
      end
    end

    // Misaligned half load at 0x3 (RAM[0] = 11223344).
    run_txn(1'b0, 2'd1, 1'b1, 32'h3, 32'h0, rdata, err, lat, nwe, wa, wd);
`ifdef MISALIGN_TRAP_EN
    check("mis_rdata", rdata, 32'h0000_0000);
    check("mis_err", 32'(err), 32'd1);
    check("mis_lat", 32'(lat), 32'd1);
`else
    check("mis_rdata", rdata, 32'h0000_1122);
    check("mis_err", 32'(err), 32'd0);
    check("mis_lat", 32'(lat), 32'd2);
`endif
    check("mis_nwe", 32'(nwe), 32'd0);

    // Reset during the MERGE cycle of a half store: no write may reach memory.
    mwe = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 32'h8; req_wdata = 32'h0000_7777;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_merge_ra", mem_ra, 32'h8);
    if (mem_we) mwe++;
    reset = 1'b1;
    #1;
    if (mem_we) mwe++;
    check("abort_ready_async", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    if (mem_we) mwe++;
    @(negedge clk);
    if (mem_we) mwe++;
    check("abort_no_we", 32'(mwe), 32'd0);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_rdata", resp_rdata, 32'd0);
    reset = 1'b0;
    model_txn("abort_reload", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    check("abort_ram2", ram[2], 32'hDEAD_BEEF);

    // Randomized traffic against the byte-level model.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = 32'hFFFF_0000 | 32'($urandom_range(0, 255));
      else a = 32'($urandom_range(0, 255));
      model_txn($sformatf("rnd%0d", i), 1'($urandom), 2'($urandom_range(0, 3)),
                1'($urandom), a, $urandom);
    end

    // Final memory image against the model.
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[i*4 + k];
      check($sformatf("ram%0d", i), ram[i], w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
